// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake bundle between the host / round datapath and the AES-128 key-schedule sequencer.
//   master : host/datapath side, drives key_valid, mode_dec, next_key, abort
//   slave  : sequencer side, drives key_ready, control_signal, round_number, key_round,
//            rk_valid, done, busy, err
interface aes_key_sched_ctrl_if;
  logic       key_valid;
  logic       key_ready;
  logic       mode_dec;
  logic       next_key;
  logic       abort;
  logic [1:0] control_signal;
  logic [3:0] round_number;
  logic [3:0] key_round;
  logic       rk_valid;
  logic       done;
  logic       busy;
  logic       err;

  modport master (
    output key_valid, mode_dec, next_key, abort,
    input  key_ready, control_signal, round_number, key_round, rk_valid, done, busy, err
  );

  modport slave (
    input  key_valid, mode_dec, next_key, abort,
    output key_ready, control_signal, round_number, key_round, rk_valid, done, busy, err
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES-128 round-key scheduler.
//   Encrypt: load key, then step forward rounds 1..10 on next_key.
//   Decrypt: load key, pre-expand to round 10 automatically, then step back 9..0 on next_key.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - aes_key_sched_ctrl_if.slave (host handshake, scheduler control, status)
// Build option:
//   AES_KSC_ERR_EN - when defined, bus.err is a sticky protocol-error flag; otherwise tied 0.
module aes_key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic                 clk,
  input logic                 rst,
  aes_key_sched_ctrl_if.slave bus
);

  localparam logic [3:0] LastRnd = 4'(NUM_ROUNDS);

  localparam logic [1:0] CtrlHold    = 2'b00;
  localparam logic [1:0] CtrlLoad    = 2'b01;
  localparam logic [1:0] CtrlForward = 2'b10;
  localparam logic [1:0] CtrlReverse = 2'b11;

  typedef enum logic [1:0] {StIdle, StPreexp, StReady} state_e;

  state_e     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       dec_q, dec_d;
  logic       done_q, done_d;
  logic [1:0] ctrl;
  logic [3:0] rnd_num;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    ctrl    = CtrlHold;
    rnd_num = 4'd0;
    unique case (state_q)
      StIdle: begin
        if (bus.key_valid) begin
          ctrl    = CtrlLoad;
          rnd_d   = 4'd0;
          dec_d   = bus.mode_dec;
          state_d = bus.mode_dec ? StPreexp : StReady;
        end
      end
      StPreexp: begin
        if (bus.abort) begin
          state_d = StIdle;
          rnd_d   = 4'd0;
        end else begin
          ctrl    = CtrlForward;
          rnd_num = rnd_q + 4'd1;
          rnd_d   = rnd_q + 4'd1;
          if (rnd_q + 4'd1 == LastRnd) state_d = StReady;
        end
      end
      StReady: begin
        if (bus.abort) begin
          state_d = StIdle;
          rnd_d   = 4'd0;
        end else if (bus.next_key) begin
          if (!dec_q && rnd_q < LastRnd) begin
            ctrl    = CtrlForward;
            rnd_num = rnd_q + 4'd1;
            rnd_d   = rnd_q + 4'd1;
          end else if (dec_q && rnd_q != 4'd0) begin
            // Reverse step uses the Rcon of the key being undone, i.e. the current round.
            ctrl    = CtrlReverse;
            rnd_num = rnd_q;
            rnd_d   = rnd_q - 4'd1;
          end else begin
            // Terminal key consumed: scheduler holds, rnd kept until the next load.
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rnd_q   <= 4'd0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign bus.control_signal = ctrl;
  assign bus.round_number   = rnd_num;
  assign bus.key_round      = rnd_q;
  assign bus.key_ready      = (state_q == StIdle);
  assign bus.busy           = (state_q != StIdle);
  assign bus.rk_valid       = (state_q == StReady);
  assign bus.done           = done_q;

`ifdef AES_KSC_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.key_valid && state_q != StIdle) err_d = 1'b1;
    if (bus.next_key && state_q != StReady) err_d = 1'b1;
    if (bus.abort && state_q == StIdle)     err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
